spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master. It takes a start request plus a transmit word and drives one complete SPI mode-0 frame: ss_n framing, sclk generation, MSB-first shift-out on mosi, and shift-in from miso. It sits between the Avalon register bank (start/data/divider registers) and the SPI pins. It reports busy and a one-cycle done pulse, and returns the received word.

Parameters:
- DATA_BYTES, 4, frame length in bytes; N = DATA_BYTES*8 bits per frame.
- DIV_W, 8, width of the sclk divider input.

Ports:
- clk, input, 1, the single clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, transfer request; sampled only in IDLE.
- tx_data, input, N, word to transmit; latched when start is accepted.
- clk_div, input, DIV_W, sclk half-period minus one (in clk cycles); latched when start is accepted.
- busy, output, 1, high from the cycle after acceptance until done.
- done, output, 1, one-cycle pulse at end of frame.
- rx_data, output, N, last received word; updated in the done cycle.
- sclk, output, 1, SPI clock; idles low (CPOL=0).
- mosi, output, 1, SPI data out.
- miso, input, 1, SPI data in.
- ss_n, output, 1, active-low slave select.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, rx_data=0, sclk=0, mosi=0, ss_n=1, state=IDLE, counters=0.
- Let D = latched clk_div. A half-period is D+1 clk cycles. A divider counter runs 0..D; the terminal count (tc) fires when counter==D, and the counter reloads to 0 on tc and on every state entry.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
- IDLE, start=1: latch tx_data into the shift register and latch clk_div. Next cycle: state=LEAD, busy=1, ss_n=0, mosi=tx_data[N-1].
- LEAD on tc: go to SHIFT and drive sclk=1 (rising edge 1).
- SHIFT on tc: toggle sclk.
  - Toggle 0->1 (rising edge): sample miso into the rx shift register LSB, shifting left.
  - Toggle 1->0 (falling edge): if bit_cnt < N-1, shift tx left, drive the next bit on mosi, and increment bit_cnt.
  - The N-th falling edge goes to TRAIL; sclk stays 0.
- TRAIL on tc: go to IDLE with ss_n=1, busy=0, done=1 for exactly one cycle, rx_data = rx shift register, mosi=0.
- Frame timing: busy is high for exactly (2N+2)*(D+1) cycles. Example: N=32, D=0 gives 66 cycles.
- Mode 0 compliance: mosi changes only on a falling sclk edge or on LEAD entry; miso is sampled only on a rising edge.
- start while busy is ignored; no queueing.
- start asserted in the done cycle is accepted, and the next frame's LEAD begins on the following cycle.
- tx_data and clk_div changes during a frame have no effect.
- D=0: sclk = clk/2. D=max: half-period is 2^DIV_W cycles.
- Counter widths: bit_cnt is $clog2(N) bits; the divider counter is DIV_W bits with no overflow.
- Reset mid-frame: outputs return to reset values immediately and asynchronously; rx_data is cleared and no done pulse is issued.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- Defined: adds input loopback (1 bit). When loopback=1, the rx shift register samples the internal mosi instead of miso, and the pins are still driven normally.
- Undefined: the loopback port and mux are absent, and miso is always sampled.

Decomposition:
- Shared package spi_pkg:
  - xfer_state_t enum {IDLE, LEAD, SHIFT, TRAIL}.
  - Localparam SPI_WORD_W = DATA_BYTES*8.
  - Reset constants for the pin outputs.
- One sub-module, spi_clk_div: a DIV_W-bit half-period counter with a clear input and a tc output. The FSM and shift registers stay in spi_xfer_ctrl.

Test Plan:
1. DATA_BYTES=4, clk_div=0, tx_data=32'hA5C3_0F81, miso wired to mosi -> 32 sclk rising edges, busy high 66 cycles, done pulse once, rx_data=32'hA5C3_0F81, ss_n low for 66 cycles.
2. clk_div=3, tx_data=32'h8000_0001, miso held 1 -> sclk period 8 clk, busy 264 cycles, first mosi bit 1, rx_data=32'hFFFF_FFFF; check mosi is stable across every rising edge.
3. Start pulse at cycle 10 of an active frame with tx_data=32'h1234_5678 -> ignored; only the original frame completes and a single done pulse is seen.
4. Start held high through done, with tx_data changed to 32'h0000_00FF -> second frame's LEAD starts on the cycle after done, and the second rx matches 32'h0000_00FF under loopback wiring.
5. Assert reset during SHIFT at bit 17 -> same cycle: ss_n=1, sclk=0, busy=0, no done; after release, a new frame with tx_data=32'hDEAD_BEEF completes correctly.
6. SPI_LOOPBACK_EN defined, loopback=1, miso tied 0, tx_data=32'hC0FF_EE00 -> rx_data=32'hC0FF_EE00. With loopback=0 -> rx_data=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer path: the sequencer state
// type, default frame and divider widths, and the idle levels of the SPI pins.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LEAD,
      SHIFT,
      TRAIL
   } xfer_state_t;

   localparam int SPI_DATA_BYTES = 4;
   localparam int SPI_WORD_W     = SPI_DATA_BYTES * 8;
   localparam int SPI_DIV_W      = 8;

   localparam logic SCLK_RST = 1'b0;
   localparam logic MOSI_RST = 1'b0;
   localparam logic SS_N_RST = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for sclk generation. Counts 0..div and flags the terminal
// count; the count restarts from zero on terminal count or whenever the owner
// asserts clear (used to align every state entry to a fresh half-period).
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int DIV_W = SPI_DIV_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tc
);

   logic [DIV_W-1:0] count;

   assign tc = (count == div);

   // Free-running half-period counter. It never wraps on its own because it
   // reloads at div, so a full-scale div gives 2^DIV_W cycles per half-period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || tc) begin
         count <= '0;
      end else begin
         count <= count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 frame sequencer: frames one word with ss_n, generates sclk from a
// latched divider, shifts tx out MSB-first and captures miso into rx_data.
// Optional build macro SPI_LOOPBACK_EN adds a loopback input that feeds the
// receive shifter from the internal mosi instead of the miso pin.
module spi_xfer_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_BYTES = SPI_WORD_W / 8,
   parameter int DIV_W      = SPI_DIV_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_BYTES*8-1:0] tx_data,
   input  logic [DIV_W-1:0]        clk_div,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_BYTES*8-1:0] rx_data,
   output logic                    sclk,
   output logic                    mosi,
   input  logic                    miso,
`ifdef SPI_LOOPBACK_EN
   input  logic                    loopback,
`endif
   output logic                    ss_n
);

   localparam int N     = DATA_BYTES * 8;
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   xfer_state_t      state, stateNext;
   logic             sclkReg, sclkNext;
   logic             mosiReg, mosiNext;
   logic             ssNReg, ssNNext;
   logic             busyReg, busyNext;
   logic             doneReg, doneNext;
   logic [N-1:0]     rxData, rxDataNext;
   logic [N-1:0]     rxShift, rxShiftNext;
   logic [N-2:0]     txShift, txShiftNext;
   logic [CNT_W-1:0] bitCnt, bitCntNext;
   logic [DIV_W-1:0] divLatched, divNext;
   logic             divClear;
   logic             tc;
   logic             sampleBit;

   // The MSB of the word goes straight onto mosi at acceptance, so the tx
   // shifter only has to hold the remaining N-1 bits.
`ifdef SPI_LOOPBACK_EN
   assign sampleBit = loopback ? mosiReg : miso;
`else
   assign sampleBit = miso;
`endif

   assign divClear = (state == IDLE);

   spi_clk_div #(
      .DIV_W (DIV_W)
   ) divider (
      .clk   (clk),
      .reset (reset),
      .clear (divClear),
      .div   (divLatched),
      .tc    (tc)
   );

   assign busy    = busyReg;
   assign done    = doneReg;
   assign rx_data = rxData;
   assign sclk    = sclkReg;
   assign mosi    = mosiReg;
   assign ss_n    = ssNReg;

   // Next-state and next-output logic. Every pin is registered, so each
   // transition here sets the value the pins will show in the following
   // cycle. TRAIL spans two half-periods of ss_n hold after the last falling
   // edge; bitCnt is free by then and marks which half we are in. That makes
   // a frame LEAD(1) + SHIFT(2N-1) + TRAIL(2) = 2N+2 half-periods long.
   always_comb begin
      stateNext   = state;
      sclkNext    = sclkReg;
      mosiNext    = mosiReg;
      ssNNext     = ssNReg;
      busyNext    = busyReg;
      doneNext    = 1'b0;
      rxDataNext  = rxData;
      rxShiftNext = rxShift;
      txShiftNext = txShift;
      bitCntNext  = bitCnt;
      divNext     = divLatched;
      unique case (state)
         IDLE: begin
            if (start) begin
               stateNext   = LEAD;
               txShiftNext = tx_data[N-2:0];
               divNext     = clk_div;
               busyNext    = 1'b1;
               ssNNext     = 1'b0;
               mosiNext    = tx_data[N-1];
               bitCntNext  = '0;
               rxShiftNext = '0;
            end
         end
         LEAD: begin
            if (tc) begin
               stateNext   = SHIFT;
               sclkNext    = 1'b1;
               rxShiftNext = {rxShift[N-2:0], sampleBit};
            end
         end
         SHIFT: begin
            if (tc) begin
               if (sclkReg) begin
                  sclkNext = 1'b0;
                  if (bitCnt < LAST_BIT) begin
                     mosiNext    = txShift[N-2];
                     txShiftNext = {txShift[N-3:0], 1'b0};
                     bitCntNext  = bitCnt + CNT_W'(1);
                  end else begin
                     stateNext  = TRAIL;
                     bitCntNext = '0;
                  end
               end else begin
                  sclkNext    = 1'b1;
                  rxShiftNext = {rxShift[N-2:0], sampleBit};
               end
            end
         end
         TRAIL: begin
            if (tc) begin
               if (bitCnt == '0) begin
                  bitCntNext = CNT_W'(1);
               end else begin
                  stateNext  = IDLE;
                  ssNNext    = 1'b1;
                  busyNext   = 1'b0;
                  doneNext   = 1'b1;
                  rxDataNext = rxShift;
                  mosiNext   = 1'b0;
                  bitCntNext = '0;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops everything back to the idle pin
   // levels immediately, discarding any frame in progress without a done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sclkReg    <= SCLK_RST;
         mosiReg    <= MOSI_RST;
         ssNReg     <= SS_N_RST;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         rxData     <= '0;
         rxShift    <= '0;
         txShift    <= '0;
         bitCnt     <= '0;
         divLatched <= '0;
      end else begin
         state      <= stateNext;
         sclkReg    <= sclkNext;
         mosiReg    <= mosiNext;
         ssNReg     <= ssNNext;
         busyReg    <= busyNext;
         doneReg    <= doneNext;
         rxData     <= rxDataNext;
         rxShift    <= rxShiftNext;
         txShift    <= txShiftNext;
         bitCnt     <= bitCntNext;
         divLatched <= divNext;
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl (default 32-bit frame, 8-bit divider).
// Build with SPI_LOOPBACK_EN defined to also exercise the loopback input.
module tb_spi_xfer_ctrl;

   localparam int N = 32;

   typedef struct {
      logic [31:0] tx;
      logic [31:0] rx;
      int          div;
   } frame_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] tx_data = '0;
   logic [7:0]  clk_div = '0;
   logic        busy;
   logic        done;
   logic [31:0] rx_data;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        ss_n;
`ifdef SPI_LOOPBACK_EN
   logic        loopback = 1'b0;
`endif

   frame_t      sb[$];
   int          checks = 0;
   int          errors = 0;
   int          busyRun = 0;
   int          ssRun = 0;
   int          riseCnt = 0;
   int          gapCnt = 0;
   int          gapBad = 0;
   int          mosiBad = 0;
   int          donesSeen = 0;
   int          framesIssued = 0;
   int          framesAborted = 0;
   logic [31:0] mosiWord = '0;
   logic        prevSclk = 1'b0;
   logic        prevMosi = 1'b0;
   logic [1:0]  misoMode = 2'd0;
   logic        misoConst = 1'b0;
   logic [31:0] slaveWord = '0;
   logic        slaveBit;

   spi_xfer_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .tx_data  (tx_data),
      .clk_div  (clk_div),
      .busy     (busy),
      .done     (done),
      .rx_data  (rx_data),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
`ifdef SPI_LOOPBACK_EN
      .loopback (loopback),
`endif
      .ss_n     (ss_n)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Slave model: presents its word MSB first, one new bit per sclk cycle.
   always_comb begin
      slaveBit = 1'b0;
      if (riseCnt < N) slaveBit = slaveWord[N-1-riseCnt];
   end

   // miso source: wired back to mosi, held constant, or driven by the slave.
   assign miso = (misoMode == 2'd0) ? mosi :
                 (misoMode == 2'd1) ? misoConst : slaveBit;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic void clearFrame();
      busyRun  = 0;
      ssRun    = 0;
      riseCnt  = 0;
      gapCnt   = 0;
      gapBad   = 0;
      mosiBad  = 0;
      mosiWord = '0;
   endfunction

   // Waits for the sequencer to be idle, then issues one start and records
   // what the frame must return: the tx word under loopback wiring, all
   // copies of a constant miso level, or the slave's word.
   task automatic applyStimulus(input logic [31:0] tx, input int div,
                                input logic [1:0] mode, input logic cval,
                                input logic [31:0] sword, input logic lb);
      int     waitCnt = 0;
      frame_t f;
      while (busy && waitCnt < 20000) begin
         @(negedge clk);
         waitCnt++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle_timeout: busy still %b, required 0", busy);
      end
      misoMode  = mode;
      misoConst = cval;
      slaveWord = sword;
`ifdef SPI_LOOPBACK_EN
      loopback  = lb;
`endif
      f.tx  = tx;
      f.div = div;
      if (lb) f.rx = tx;
      else if (mode == 2'd0) f.rx = tx;
      else if (mode == 2'd1) f.rx = {32{cval}};
      else f.rx = sword;
      tx_data = tx;
      clk_div = 8'(div);
      start   = 1'b1;
      sb.push_back(f);
      framesIssued++;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sb.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d frames pending, required 0", sb.size());
      end
   endtask

   // Monitor: measures each frame on the pins and, on every done pulse,
   // compares the measurements with the oldest scoreboard entry.
   always @(negedge clk) begin
      frame_t exp;
      if (reset) begin
         clearFrame();
         prevSclk = 1'b0;
         prevMosi = 1'b0;
      end else begin
         if (busy) busyRun++;
         if (!ss_n) ssRun++;
         if (busy) gapCnt++;
         if (sclk && !prevSclk) begin
            if (riseCnt > 0 && sb.size() > 0 && gapCnt != 2 * (sb[0].div + 1)) gapBad++;
            gapCnt = 0;
            if (mosi !== prevMosi) mosiBad++;
            mosiWord = {mosiWord[30:0], mosi};
            riseCnt++;
         end
         if (done) begin
            donesSeen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: done with rx_data=%0h, required no pulse", rx_data);
            end else begin
               exp = sb.pop_front();
               checkOutput("rx_data", rx_data, exp.rx);
               checkOutput("busy_cycles", busyRun, (2 * N + 2) * (exp.div + 1));
               checkOutput("ss_n_low_cycles", ssRun, (2 * N + 2) * (exp.div + 1));
               checkOutput("sclk_rises", riseCnt, N);
               checkOutput("mosi_word", mosiWord, exp.tx);
               checkOutput("mosi_unstable_at_rise", mosiBad, 0);
               checkOutput("sclk_period_errors", gapBad, 0);
            end
            clearFrame();
         end
         prevSclk = sclk;
         prevMosi = mosi;
      end
   end

   // Global time limit so a stuck design still ends the run.
   initial begin
      #3_000_000;
      $display("[TB] FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "[TB] global timeout");
   end

   // Directed scenarios followed by randomized frames.
   initial begin
      int n;
      logic [1:0] mode;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_rx_data", rx_data, 0);
      checkOutput("rst_sclk", sclk, 0);
      checkOutput("rst_mosi", mosi, 0);
      checkOutput("rst_ss_n", ss_n, 1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] loopback wiring, divider 0");
      applyStimulus(32'hA5C3_0F81, 0, 2'd0, 1'b0, 32'h0, 1'b0);
      waitDrain();

      $display("[TB] miso held high, divider 3");
      applyStimulus(32'h8000_0001, 3, 2'd1, 1'b1, 32'h0, 1'b0);
      waitDrain();

      $display("[TB] start while busy is ignored");
      applyStimulus($urandom | 32'h1, 1, 2'd0, 1'b0, 32'h0, 1'b0);
      repeat (9) @(negedge clk);
      tx_data = 32'h1234_5678;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDrain();
      repeat (3) @(negedge clk);
      checkOutput("ignored_start_idle", busy, 0);

      $display("[TB] start held through done");
      applyStimulus($urandom, 0, 2'd0, 1'b0, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      tx_data = 32'h0000_00FF;
      clk_div = 8'd1;
      start   = 1'b1;
      n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL b2b_done_timeout: done %b, required 1", done);
      end else begin
         frame_t f;
         f.tx  = 32'h0000_00FF;
         f.rx  = 32'h0000_00FF;
         f.div = 1;
         sb.push_back(f);
         framesIssued++;
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_lead_busy", busy, 1);
      checkOutput("b2b_lead_ss_n", ss_n, 0);
      waitDrain();

      $display("[TB] reset in the middle of a frame");
      applyStimulus($urandom, 1, 2'd2, 1'b0, $urandom, 1'b0);
      n = 0;
      while (riseCnt < 18 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reset_reached_bit17", riseCnt, 18);
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_ss_n", ss_n, 1);
      checkOutput("midrst_sclk", sclk, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_rx_data", rx_data, 0);
      checkOutput("midrst_mosi", mosi, 0);
      framesAborted += sb.size();
      sb.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(32'hDEAD_BEEF, 2, 2'd0, 1'b0, 32'h0, 1'b0);
      waitDrain();

`ifdef SPI_LOOPBACK_EN
      $display("[TB] loopback input");
      applyStimulus(32'hC0FF_EE00, 0, 2'd1, 1'b0, 32'h0, 1'b1);
      waitDrain();
      applyStimulus(32'hC0FF_EE00, 0, 2'd1, 1'b0, 32'h0, 1'b0);
      waitDrain();
`endif

      $display("[TB] randomized frames");
      for (int i = 0; i < 10; i++) begin
         mode = 2'($urandom_range(0, 2));
         applyStimulus($urandom, $urandom_range(0, 5), mode,
                       1'($urandom_range(0, 1)), $urandom, 1'b0);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      waitDrain();

      $display("[TB] maximum divider");
      applyStimulus($urandom, 255, 2'd2, 1'b0, $urandom, 1'b0);
      waitDrain();

      repeat (5) @(negedge clk);
      checkOutput("done_count", donesSeen, framesIssued - framesAborted);
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
